// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor: zero-latency lookup on the fetch PC,
// training and mispredict detection from execute, plus statistics counters.
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   input  logic        resolve_valid_i,
   input  logic        is_jump_i,
   input  logic        actual_taken_i,
   input  logic [31:0] PCE,
   input  logic [31:0] PCPlus4E,
   input  logic [31:0] actual_target_i,
   input  logic        pred_taken_e_i,
   input  logic [31:0] pred_target_e_i,
   output logic        pc_predict_redirect_o,
   output logic [31:0] predicted_target_pc_o,
   output logic        pc_redirect_o,
   output logic [31:0] mispredict_target_pc_o,
   output logic [31:0] branch_count_o,
   output logic [31:0] mispredict_count_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [31:0]        branch_cnt_q, branch_cnt_d;
   logic [31:0]        mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] f_idx, e_idx;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic             f_hit, e_hit;
   logic             taken, mispredict;
   logic             wr_en;
   logic [31:0]      wr_target_d;
   logic [1:0]       wr_ctr_d;
   logic             unused_pc_bits;

   // Instructions are word aligned, so the low PC bits carry no information.
   assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

   assign f_idx = PCF[IDX_W+1:2];
   assign f_tag = PCF[31:IDX_W+2];
   assign e_idx = PCE[IDX_W+1:2];
   assign e_tag = PCE[31:IDX_W+2];

   always_comb begin
      f_hit                 = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      pc_predict_redirect_o = f_hit && ctr_q[f_idx][1];
      predicted_target_pc_o = f_hit ? target_q[f_idx] : 32'h0;
   end

   always_comb begin
      taken      = is_jump_i | actual_taken_i;
      mispredict = resolve_valid_i &
                   ((pred_taken_e_i != taken) |
                    (pred_taken_e_i & taken & (pred_target_e_i != actual_target_i)));
      pc_redirect_o          = mispredict;
      mispredict_target_pc_o = 32'h0;
      if (mispredict)
         mispredict_target_pc_o = taken ? actual_target_i : PCPlus4E;
   end

   always_comb begin
      e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
      wr_en       = resolve_valid_i && (e_hit || taken);
      wr_target_d = actual_target_i;
      wr_ctr_d    = is_jump_i ? 2'b11 : 2'b10;
      if (e_hit) begin
         if (taken) begin
            wr_ctr_d = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'b01;
         end else begin
            wr_ctr_d    = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'b01;
            wr_target_d = target_q[e_idx];
         end
      end
   end

   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (resolve_valid_i && (branch_cnt_q != 32'hFFFF_FFFF))
         branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
         mispred_cnt_d = mispred_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (wr_en) begin
            valid_q[e_idx]  <= 1'b1;
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= wr_target_d;
            ctr_q[e_idx]    <= wr_ctr_d;
         end
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_count_o     = branch_cnt_q;
   assign mispredict_count_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PCF;
   logic        resolve_valid_i, is_jump_i, actual_taken_i, pred_taken_e_i;
   logic [31:0] PCE, PCPlus4E, actual_target_i, pred_target_e_i;
   logic        pc_predict_redirect_o, pc_redirect_o;
   logic [31:0] predicted_target_pc_o, mispredict_target_pc_o;
   logic [31:0] branch_count_o, mispredict_count_o;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .PCF                    (PCF),
      .resolve_valid_i        (resolve_valid_i),
      .is_jump_i              (is_jump_i),
      .actual_taken_i         (actual_taken_i),
      .PCE                    (PCE),
      .PCPlus4E               (PCPlus4E),
      .actual_target_i        (actual_target_i),
      .pred_taken_e_i         (pred_taken_e_i),
      .pred_target_e_i        (pred_target_e_i),
      .pc_predict_redirect_o  (pc_predict_redirect_o),
      .predicted_target_pc_o  (predicted_target_pc_o),
      .pc_redirect_o          (pc_redirect_o),
      .mispredict_target_pc_o (mispredict_target_pc_o),
      .branch_count_o         (branch_count_o),
      .mispredict_count_o     (mispredict_count_o)
   );

   always #5 clk = ~clk;

   task automatic report(input string tag, input bit ok,
                         input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic resolve(input logic v, input logic j, input logic t,
                          input logic [31:0] pce, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
      resolve_valid_i = v;
      is_jump_i       = j;
      actual_taken_i  = t;
      PCE             = pce;
      PCPlus4E        = pce + 32'd4;
      actual_target_i = tgt;
      pred_taken_e_i  = pt;
      pred_target_e_i = ptgt;
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      PCF = 32'h100;
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      report("rst_pred", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);
      report("rst_ptgt", predicted_target_pc_o === 32'h0, predicted_target_pc_o, 32'h0);
      report("rst_redir", pc_redirect_o === 1'b0, pc_redirect_o, 1'b0);
      report("rst_mtgt", mispredict_target_pc_o === 32'h0, mispredict_target_pc_o, 32'h0);
      report("rst_bcnt", branch_count_o === 32'd0, branch_count_o, 32'd0);
      report("rst_mcnt", mispredict_count_o === 32'd0, mispredict_count_o, 32'd0);

      // Taken branch, predicted not-taken: allocate with ctr=10
      resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
      #1;
      report("alloc_redir", pc_redirect_o === 1'b1, pc_redirect_o, 1'b1);
      report("alloc_mtgt", mispredict_target_pc_o === 32'h80, mispredict_target_pc_o, 32'h80);
      report("alloc_samecyc_pred", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("alloc_pred", pc_predict_redirect_o === 1'b1, pc_predict_redirect_o, 1'b1);
      report("alloc_ptgt", predicted_target_pc_o === 32'h80, predicted_target_pc_o, 32'h80);
      report("alloc_bcnt", branch_count_o === 32'd1, branch_count_o, 32'd1);
      report("alloc_mcnt", mispredict_count_o === 32'd1, mispredict_count_o, 32'd1);

      // Not taken while predicted taken: redirect to fall-through, ctr 10->01
      resolve(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
      #1;
      report("nt1_redir", pc_redirect_o === 1'b1, pc_redirect_o, 1'b1);
      report("nt1_mtgt", mispredict_target_pc_o === 32'h104, mispredict_target_pc_o, 32'h104);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("nt1_pred", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);
      report("nt1_ptgt", predicted_target_pc_o === 32'h80, predicted_target_pc_o, 32'h80);

      // Not taken, correctly predicted: no redirect, ctr 01->00
      resolve(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0);
      #1;
      report("nt2_redir", pc_redirect_o === 1'b0, pc_redirect_o, 1'b0);
      report("nt2_mtgt", mispredict_target_pc_o === 32'h0, mispredict_target_pc_o, 32'h0);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("nt2_bcnt", branch_count_o === 32'd3, branch_count_o, 32'd3);
      report("nt2_mcnt", mispredict_count_o === 32'd2, mispredict_count_o, 32'd2);
      report("nt2_pred", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);

      // ctr at 00: two taken resolves needed before predicting taken again
      resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h88, 1'b0, 32'h0);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("t1_pred", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);
      report("t1_ptgt", predicted_target_pc_o === 32'h88, predicted_target_pc_o, 32'h88);
      resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h90, 1'b0, 32'h0);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("t2_pred", pc_predict_redirect_o === 1'b1, pc_predict_redirect_o, 1'b1);
      report("t2_ptgt", predicted_target_pc_o === 32'h90, predicted_target_pc_o, 32'h90);

      // Alias: 0x140 shares index 0 with 0x100; same-cycle lookup sees old entry
      resolve(1'b1, 1'b0, 1'b1, 32'h140, 32'h10, 1'b0, 32'h0);
      #1;
      report("alias_redir", pc_redirect_o === 1'b1, pc_redirect_o, 1'b1);
      report("alias_mtgt", mispredict_target_pc_o === 32'h10, mispredict_target_pc_o, 32'h10);
      report("alias_samecyc_pred", pc_predict_redirect_o === 1'b1, pc_predict_redirect_o, 1'b1);
      report("alias_samecyc_ptgt", predicted_target_pc_o === 32'h90, predicted_target_pc_o, 32'h90);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("alias_old_pred", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);
      report("alias_old_ptgt", predicted_target_pc_o === 32'h0, predicted_target_pc_o, 32'h0);
      PCF = 32'h140;
      #1;
      report("alias_new_pred", pc_predict_redirect_o === 1'b1, pc_predict_redirect_o, 1'b1);
      report("alias_new_ptgt", predicted_target_pc_o === 32'h10, predicted_target_pc_o, 32'h10);
      report("alias_bcnt", branch_count_o === 32'd6, branch_count_o, 32'd6);
      report("alias_mcnt", mispredict_count_o === 32'd5, mispredict_count_o, 32'd5);

      // Jump with actual_taken_i=0 still counts as taken; allocates ctr=11
      resolve(1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 1'b0, 32'h0);
      #1;
      report("jal_redir", pc_redirect_o === 1'b1, pc_redirect_o, 1'b1);
      report("jal_mtgt", mispredict_target_pc_o === 32'h300, mispredict_target_pc_o, 32'h300);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      PCF = 32'h200;
      #1;
      report("jal_pred", pc_predict_redirect_o === 1'b1, pc_predict_redirect_o, 1'b1);
      report("jal_ptgt", predicted_target_pc_o === 32'h300, predicted_target_pc_o, 32'h300);

      // JALR: direction right, target wrong
      resolve(1'b1, 1'b1, 1'b0, 32'h200, 32'h340, 1'b1, 32'h300);
      #1;
      report("jalr_redir", pc_redirect_o === 1'b1, pc_redirect_o, 1'b1);
      report("jalr_mtgt", mispredict_target_pc_o === 32'h340, mispredict_target_pc_o, 32'h340);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("jalr_pred", pc_predict_redirect_o === 1'b1, pc_predict_redirect_o, 1'b1);
      report("jalr_ptgt", predicted_target_pc_o === 32'h340, predicted_target_pc_o, 32'h340);

      // Fully correct taken prediction
      resolve(1'b1, 1'b1, 1'b0, 32'h200, 32'h340, 1'b1, 32'h340);
      #1;
      report("ok_redir", pc_redirect_o === 1'b0, pc_redirect_o, 1'b0);
      report("ok_mtgt", mispredict_target_pc_o === 32'h0, mispredict_target_pc_o, 32'h0);
      step();
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      report("ok_bcnt", branch_count_o === 32'd9, branch_count_o, 32'd9);
      report("ok_mcnt", mispredict_count_o === 32'd7, mispredict_count_o, 32'd7);

      // Reset with a simultaneous resolve: reset wins, nothing allocated
      rst = 1'b1;
      resolve(1'b1, 1'b1, 1'b1, 32'h400, 32'h500, 1'b0, 32'h0);
      step();
      rst = 1'b0;
      resolve(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      PCF = 32'h400;
      #1;
      report("rst2_pred400", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);
      report("rst2_ptgt400", predicted_target_pc_o === 32'h0, predicted_target_pc_o, 32'h0);
      PCF = 32'h200;
      #1;
      report("rst2_pred200", pc_predict_redirect_o === 1'b0, pc_predict_redirect_o, 1'b0);
      report("rst2_bcnt", branch_count_o === 32'd0, branch_count_o, 32'd0);
      report("rst2_mcnt", mispredict_count_o === 32'd0, mispredict_count_o, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
